// File: rtl/fpu_mul_div_arbiter.sv
// Round-robin arbiter sharing one half-precision mul/div unit between two requesters.
// Optional RUN-state watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_mul_div_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        mulDiv0,
   input  logic        mulDiv1,
   input  logic [15:0] x0,
   input  logic [15:0] y0,
   input  logic [15:0] x1,
   input  logic [15:0] y1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   output logic [15:0] rsp_result,
   output logic [1:0]  rsp_ofuf,
   output logic        busy,
   output logic [15:0] u_x,
   output logic [15:0] u_y,
   output logic        u_mulDiv,
   output logic        u_reset,
   input  logic        u_done,
   input  logic [15:0] u_result,
   input  logic [1:0]  u_OFUF
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t      state;
   logic        owner;
   logic        lastGnt;
   logic        loadFlop;
   logic        pick1;
   logic [15:0] holdX;
   logic [15:0] holdY;
   logic        holdMulDiv;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt;
`endif

   // Flagged results are forced to zero so a consumer never sees a partial value.
   function automatic logic [15:0] gateResult(input logic [1:0] flags, input logic [15:0] res);
      return (flags == 2'b00) ? res : 16'h0000;
   endfunction

   // lastGnt == 1 means requester 1 was served last, so requester 0 wins a tie.
   assign pick1    = req1 & (~req0 | ~lastGnt);
   assign busy     = (state != IDLE);
   assign u_x      = holdX;
   assign u_y      = holdY;
   assign u_mulDiv = holdMulDiv;
   assign u_reset  = reset | loadFlop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         lastGnt    <= 1'b1;
         loadFlop   <= 1'b0;
         holdX      <= 16'h0000;
         holdY      <= 16'h0000;
         holdMulDiv <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         rsp_result <= 16'h0000;
         rsp_ofuf   <= 2'b00;
`ifdef FPU_ARB_TIMEOUT_EN
         cnt        <= '0;
`endif
      end else begin
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         loadFlop   <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state      <= LOAD;
                  owner      <= pick1;
                  lastGnt    <= pick1;
                  holdX      <= pick1 ? x1 : x0;
                  holdY      <= pick1 ? y1 : y0;
                  holdMulDiv <= pick1 ? mulDiv1 : mulDiv0;
                  gnt0       <= ~pick1;
                  gnt1       <= pick1;
                  loadFlop   <= 1'b1;
               end
            end
            LOAD: begin
               state <= RUN;
`ifdef FPU_ARB_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            RUN: begin
               // u_done is only honoured here; a stale pulse during LOAD is dropped.
               if (u_done) begin
                  state      <= RESP;
                  rsp_ofuf   <= u_OFUF;
                  rsp_result <= gateResult(u_OFUF, u_result);
                  rsp_valid0 <= ~owner;
                  rsp_valid1 <= owner;
`ifdef FPU_ARB_TIMEOUT_EN
               end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                  state      <= RESP;
                  rsp_ofuf   <= 2'b11;
                  rsp_result <= 16'h0000;
                  rsp_valid0 <= ~owner;
                  rsp_valid1 <= owner;
               end else begin
                  cnt <= cnt + CntW'(1);
`endif
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_div_arbiter.sv
// Directed bench for fpu_mul_div_arbiter with a delay-programmable unit model
// and a transaction-level reference checked every cycle.
module tb_fpu_mul_div_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, mulDiv0 = 1'b0, mulDiv1 = 1'b0;
   logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic        gnt0, gnt1, rsp_valid0, rsp_valid1, busy, u_mulDiv, u_reset;
   logic [15:0] rsp_result, u_x, u_y;
   logic [1:0]  rsp_ofuf;
   logic        u_done = 1'b0;
   logic [15:0] u_result = '0;
   logic [1:0]  u_OFUF = '0;

   int nCmp = 0, nFail = 0, cyc = 0;

   fpu_mul_div_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .mulDiv0(mulDiv0), .mulDiv1(mulDiv1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_result(rsp_result), .rsp_ofuf(rsp_ofuf), .busy(busy),
      .u_x(u_x), .u_y(u_y), .u_mulDiv(u_mulDiv), .u_reset(u_reset),
      .u_done(u_done), .u_result(u_result), .u_OFUF(u_OFUF));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Unit model: armed by u_reset, raises u_done doneDelay cycles later (0 = never).
   int doneDelay = 0, ucnt = 0;
   bit armed = 0, staleDone = 0;
   always @(posedge clk) begin
      #1;
      if (reset) begin
         armed = 0; ucnt = 0; u_done = 1'b0;
      end else if (u_reset) begin
         armed = 1; ucnt = 0; u_done = staleDone;
      end else if (armed) begin
         ucnt++;
         u_done = (doneDelay != 0 && ucnt == doneDelay);
         if (u_done) armed = 0;
      end else begin
         u_done = 1'b0;
      end
   end

   // Reference: one transaction at a time, aged in cycles since its grant.
   bit          active = 0, respNow = 0, own = 0, lastWin = 1;
   int          age = 0;
   logic        eGnt0 = 0, eGnt1 = 0, eRv0 = 0, eRv1 = 0, eBusy = 0, eUreset = 1, eMd = 0;
   logic [15:0] eRes = 0, eUx = 0, eUy = 0;
   logic [1:0]  eOfuf = 0;

   task automatic respond(input logic [1:0] fl, input logic [15:0] r);
      eRv0 = ~own; eRv1 = own; eOfuf = fl;
      eRes = (fl == 2'b00) ? r : 16'h0000;
      respNow = 1;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         eGnt0 = 0; eGnt1 = 0; eRv0 = 0; eRv1 = 0; eBusy = 0; eUreset = 1;
         eRes = 0; eOfuf = 0; eUx = 0; eUy = 0; eMd = 0;
      end
      chk("gnt0", gnt0, eGnt0);
      chk("gnt1", gnt1, eGnt1);
      chk("rsp_valid0", rsp_valid0, eRv0);
      chk("rsp_valid1", rsp_valid1, eRv1);
      chk("busy", busy, eBusy);
      chk("u_reset", u_reset, eUreset);
      chk("rsp_result", rsp_result, eRes);
      chk("rsp_ofuf", rsp_ofuf, eOfuf);
      chk("u_x", u_x, eUx);
      chk("u_y", u_y, eUy);
      chk("u_mulDiv", u_mulDiv, eMd);
      eGnt0 = 0; eGnt1 = 0; eRv0 = 0; eRv1 = 0; eUreset = 0;
      if (reset) begin
         active = 0; respNow = 0; lastWin = 1; eBusy = 0;
      end else if (respNow) begin
         respNow = 0; active = 0; eBusy = 0;
      end else if (!active) begin
         if (req0 || req1) begin
            own = (req0 && req1) ? ~lastWin : req1;
            lastWin = own; active = 1; age = 1;
            eUx = own ? x1 : x0; eUy = own ? y1 : y0; eMd = own ? mulDiv1 : mulDiv0;
            eGnt0 = ~own; eGnt1 = own; eBusy = 1; eUreset = 1;
         end else begin
            eBusy = 0;
         end
      end else begin
         eBusy = 1;
         if (age >= 2 && u_done) respond(u_OFUF, u_result);
`ifdef FPU_ARB_TIMEOUT_EN
         else if (age - 1 == TO) respond(2'b11, 16'h0000);
`endif
         age++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // kind 0: wait for any grant, kind 1: wait for any response.
   task automatic waitEvt(input int kind, output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (kind == 0 ? (gnt0 | gnt1) : (rsp_valid0 | rsp_valid1)) begin
            at = cyc;
            return;
         end
      end
      chk(kind == 0 ? "wait_gnt_timeout" : "wait_rsp_timeout", 16'd0, 16'd1);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   int tG, tR;
   logic order [4];

   initial begin
      tick(3);
      chk("reset_busy", busy, 16'd0);
      chk("reset_ofuf", rsp_ofuf, 16'd0);
      chk("reset_u_reset", u_reset, 16'd1);
      reset = 1'b0;
      tick(2);

      // Single multiply from requester 0
      doneDelay = 5; u_result = 16'h4000; u_OFUF = 2'b00;
      x0 = 16'h3C00; y0 = 16'h4000; mulDiv0 = 1'b0; req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
      chk("t1_gnt0", gnt0, 16'd1);
      chk("t1_umuldiv", u_mulDiv, 16'd0);
      waitEvt(1, tR);
      chk("t1_rsp_valid0", rsp_valid0, 16'd1);
      chk("t1_result", rsp_result, 16'h4000);
      chk("t1_ofuf", rsp_ofuf, 16'd0);
      chk("t1_latency", 16'(tR - tG), 16'd6);

      // Round robin with both requests held
      pulseReset();
      doneDelay = 2; u_result = 16'h1111;
      x0 = 16'h0101; y0 = 16'h0202; x1 = 16'h0303; y1 = 16'h0404; mulDiv1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         waitEvt(0, tG);
         order[k] = gnt1;
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
      waitEvt(1, tR);
      chk("rr_order0", order[0], 16'd0);
      chk("rr_order1", order[1], 16'd1);
      chk("rr_order2", order[2], 16'd0);
      chk("rr_order3", order[3], 16'd1);
      tick(2);

      // Divide by zero from requester 1
      doneDelay = 3; u_result = 16'hABCD; u_OFUF = 2'b10;
      x1 = 16'h3C00; y1 = 16'h0000; mulDiv1 = 1'b1; req1 = 1'b1;
      waitEvt(0, tG);
      req1 = 1'b0;
      chk("t3_umuldiv", u_mulDiv, 16'd1);
      waitEvt(1, tR);
      chk("t3_rsp_valid1", rsp_valid1, 16'd1);
      chk("t3_result", rsp_result, 16'h0000);
      chk("t3_ofuf", rsp_ofuf, 16'd2);
      tick(2);

      // Stale u_done during LOAD must not end the operation
      doneDelay = 4; u_result = 16'h2222; u_OFUF = 2'b00; staleDone = 1;
      req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
      tick(1);
      staleDone = 0;
      waitEvt(1, tR);
      chk("t4_latency", 16'(tR - tG), 16'd5);
      chk("t4_result", rsp_result, 16'h2222);
      tick(2);

      // req1 arriving while requester 0 runs
      doneDelay = 6; u_result = 16'h5555;
      req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
      tick(2);
      x1 = 16'h7000; y1 = 16'h0001; mulDiv1 = 1'b0; req1 = 1'b1;
      waitEvt(1, tR);
      chk("t5_rsp_valid0", rsp_valid0, 16'd1);
      doneDelay = 3; u_result = 16'h7777; u_OFUF = 2'b01;
      waitEvt(0, tG);
      req1 = 1'b0;
      chk("t5_gnt1", gnt1, 16'd1);
      chk("t5_gnt1_delay", 16'(tG - tR), 16'd2);
      waitEvt(1, tR);
      chk("t5_result", rsp_result, 16'h0000);
      chk("t5_ofuf", rsp_ofuf, 16'd1);
      tick(2);

      // Reset during RUN discards the operation
      doneDelay = 10; u_result = 16'h9999; u_OFUF = 2'b00;
      req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);
      chk("t6_u_reset", u_reset, 16'd1);
      chk("t6_busy", busy, 16'd0);
      chk("t6_ofuf", rsp_ofuf, 16'd0);
      reset = 1'b0;
      tick(15);
      doneDelay = 2; u_result = 16'h1234;
      x0 = 16'h4400; y0 = 16'h3800; mulDiv0 = 1'b1; req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
      waitEvt(1, tR);
      chk("t6_rsp_valid0", rsp_valid0, 16'd1);
      chk("t6_result", rsp_result, 16'h1234);
      tick(2);

      // Unit never completes
      doneDelay = 0;
      req0 = 1'b1;
      waitEvt(0, tG);
      req0 = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      waitEvt(1, tR);
      chk("t7_latency", 16'(tR - tG), 16'd9);
      chk("t7_ofuf", rsp_ofuf, 16'd3);
      chk("t7_result", rsp_result, 16'h0000);
`else
      tick(200);
      chk("t7_busy_hold", busy, 16'd1);
      pulseReset();
`endif
      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
